// File: rtl/reg8_bank.sv
// reg8_bank: eight-entry register bank with acknowledged writes and a
// sequenced one-word-per-cycle clear, all words exposed in parallel.
`default_nettype none

module reg8_bank #(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clear_req,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic             wr_ack,
  output logic             busy,
  output logic             clear_done
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             wr_ack_q, wr_ack_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] words_q [8];

  logic             we;
  logic [2:0]       waddr;
  logic [WIDTH-1:0] wdata;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_ack_d = 1'b0;
    done_d   = 1'b0;
    we       = 1'b0;
    waddr    = address;
    wdata    = in;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          we       = 1'b1;
          wr_ack_d = 1'b1;
        end
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = 3'd0;
        end
      end
      S_CLEAR: begin
        // load and clear_req are deliberately ignored while clearing
        we    = 1'b1;
        waddr = idx_q;
        wdata = CLEAR_VALUE;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      wr_ack_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ack_q <= wr_ack_d;
      done_q   <= done_d;
    end
  end

  // Reset zeroes storage, independent of CLEAR_VALUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) words_q[i] <= '0;
    end else if (we) begin
      words_q[waddr] <= wdata;
    end
  end

  assign q0         = words_q[0];
  assign q1         = words_q[1];
  assign q2         = words_q[2];
  assign q3         = words_q[3];
  assign q4         = words_q[4];
  assign q5         = words_q[5];
  assign q6         = words_q[6];
  assign q7         = words_q[7];
  assign wr_ack     = wr_ack_q;
  assign busy       = (state_q == S_CLEAR);
  assign clear_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg8_bank.sv
// Directed self-checking bench for reg8_bank with CLEAR_VALUE = 16'hA5A5.
`default_nettype none

module tb_reg8_bank;

  localparam logic [15:0] CV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic [2:0]  address = '0;
  logic        load = 1'b0;
  logic        clear_req = 1'b0;
  logic [15:0] q [8];
  logic        wr_ack, busy, clear_done;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  reg8_bank #(.WIDTH(16), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .reset(reset), .in(din), .address(address), .load(load),
    .clear_req(clear_req),
    .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
    .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7]),
    .wr_ack(wr_ack), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) chk16($sformatf("%s_q%0d", tag, i), q[i], exp);
  endtask

  initial begin
    int cnt;
    logic [15:0] v;

    // Power-on reset
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    chk_all("por", 16'h0000);
    chk1("por_busy", busy, 1'b0);
    chk1("por_ack", wr_ack, 1'b0);
    chk1("por_done", clear_done, 1'b0);

    // Asynchronous reset mid-cycle, right after a write is acknowledged
    load = 1'b1; address = 3'd2; din = 16'hDEAD;
    tick();
    load = 1'b0;
    chk16("pre_rst_q2", q[2], 16'hDEAD);
    chk1("pre_rst_ack", wr_ack, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk16("async_rst_q2", q[2], 16'h0000);
    chk1("async_rst_ack", wr_ack, 1'b0);
    tick();
    #2 reset = 1'b0;

    // Write sweep on consecutive cycles
    tick();
    for (int n = 0; n < 8; n++) begin
      load = 1'b1; address = 3'(n); din = 16'(16'h1111 * (n + 1));
      tick();
      chk1($sformatf("sweep_ack%0d", n), wr_ack, 1'b1);
      chk16($sformatf("sweep_q%0d", n), q[n], 16'(16'h1111 * (n + 1)));
    end
    load = 1'b0;
    tick();
    chk1("sweep_ack_off", wr_ack, 1'b0);
    for (int n = 0; n < 8; n++) chk16($sformatf("sweep_hold_q%0d", n), q[n], 16'(16'h1111 * (n + 1)));

    // One-cycle clear request; words cleared in order, one per edge
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk1($sformatf("clr_busy%0d", k), busy, 1'b1);
      chk1($sformatf("clr_nodone%0d", k), clear_done, 1'b0);
      chk16($sformatf("clr_before_q%0d", k), q[k], 16'(16'h1111 * (k + 1)));
      tick();
      chk16($sformatf("clr_after_q%0d", k), q[k], CV);
      if (k < 7) chk16($sformatf("clr_next_q%0d", k + 1), q[k + 1], 16'(16'h1111 * (k + 2)));
    end
    chk1("clr_busy_end", busy, 1'b0);
    chk1("clr_done", clear_done, 1'b1);
    tick();
    chk1("clr_done_once", clear_done, 1'b0);

    // Load held high throughout a clear is ignored, accepted once idle
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    load = 1'b1; address = 3'd3; din = 16'hBEEF;
    for (int k = 0; k < 8; k++) begin
      chk1($sformatf("lic_busy%0d", k), busy, 1'b1);
      tick();
      chk1($sformatf("lic_ack%0d", k), wr_ack, 1'b0);
    end
    chk1("lic_idle", busy, 1'b0);
    chk1("lic_done", clear_done, 1'b1);
    chk16("lic_q3_cleared", q[3], CV);
    tick();
    load = 1'b0;
    chk16("lic_retry_q3", q[3], 16'hBEEF);
    chk1("lic_retry_ack", wr_ack, 1'b1);

    // Simultaneous load and clear_req in IDLE
    load = 1'b1; address = 3'd5; din = 16'h1234; clear_req = 1'b1;
    tick();
    load = 1'b0; clear_req = 1'b0;
    chk16("sim_q5", q[5], 16'h1234);
    chk1("sim_ack", wr_ack, 1'b1);
    chk1("sim_busy", busy, 1'b1);
    repeat (8) tick();
    chk1("sim_done", clear_done, 1'b1);
    chk16("sim_q5_cleared", q[5], CV);
    chk16("sim_q3_cleared", q[3], CV);

    // Reset while idx=4 aborts the clear
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    chk16("mid_q3_cleared", q[3], CV);
    chk1("mid_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_all("mid_rst", 16'h0000);
    chk1("mid_rst_busy", busy, 1'b0);
    tick();
    #2 reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (clear_done) cnt++;
      if (busy) cnt++;
    end
    chk16("mid_no_activity", 16'(cnt), 16'd0);
    chk16("mid_q0_zero", q[0], 16'h0000);

    // Full clear after the aborted one
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
    end
    chk16("full_busy_len", 16'(cnt), 16'd8);
    chk1("full_done", clear_done, 1'b1);
    chk_all("full", CV);

    // clear_req held continuously: busy drops for exactly one cycle
    tick();
    v = 16'h0;
    clear_req = 1'b1;
    tick();
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
    end
    chk16("cont_busy_len", 16'(cnt), 16'd8);
    chk1("cont_gap_busy", busy, 1'b0);
    chk1("cont_gap_done", clear_done, 1'b1);
    tick();
    clear_req = 1'b0;
    chk1("cont_restart", busy, 1'b1);
    repeat (8) tick();
    chk1("cont_end_busy", busy, 1'b0);
    chk1("cont_no_third", v[0], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg8_bank.md
# reg8_bank

Eight-entry, 16-bit register bank that drives the eight data inputs of the 8-way 16-bit word selector in the basic datapath. Writes one word per cycle under an acknowledged load, and runs a sequencing state machine that clears all eight words, one per cycle, on request. All eight stored words are exposed in parallel, so the downstream selector picks the read word combinationally with its own 3-bit select.

## Interface
Parameters:
- WIDTH, 16, word width; must match the downstream selector.
- CLEAR_VALUE, 16'h0000, value written to every word by a clear sequence.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately, released synchronously to clk.
- in  input  WIDTH  write data.
- address  input  3  write address (0–7).
- load  input  1  write request for the current cycle.
- clear_req  input  1  request to start a clear sequence.
- q0 … q7  output  WIDTH each  stored words; qN drives selector input inN.
- wr_ack  output  1  high for one cycle after an accepted write.
- busy  output  1  high while a clear sequence is in progress.
- clear_done  output  1  one-cycle pulse after the last word of a clear is written.

## Operation
- Storage: eight WIDTH-bit registers. qN is a direct register output; no combinational path from any input to any qN.
- FSM states:
  - IDLE: accepts writes. Exits to CLEAR when clear_req=1.
  - CLEAR: holds a 3-bit index idx.
- IDLE behaviour:
  - load=1 → reg[address] ← in at the edge; wr_ack=1 during the next cycle.
  - clear_req=1 → at the edge, idx←0 and the FSM enters CLEAR.
  - load=1 and clear_req=1 together: the write is performed and acknowledged, and CLEAR is entered at the same edge. The clear later overwrites that word.
- CLEAR behaviour:
  - Each edge writes reg[idx] ← CLEAR_VALUE and increments idx.
  - At the edge where idx=7, the FSM returns to IDLE and clear_done=1 for the following cycle.
  - load is ignored in CLEAR: no write, and wr_ack stays 0. The writer must retry after busy falls.
  - clear_req is ignored in CLEAR: no restart or extension.
- busy=1 exactly while the FSM is in CLEAR.
- idx wraps 7→0 only by leaving CLEAR. idx is never observable outside the block.
- Reset values: q0–q7=0 (not CLEAR_VALUE), FSM=IDLE, idx=0, wr_ack=0, busy=0, clear_done=0.
- Reset asserted mid-clear aborts the sequence. Words already cleared stay cleared only until reset zeroes all words.

## Timing
- Write latency: 1 edge. Data on qN is visible in the cycle after the load edge, the same cycle wr_ack is high.
- Clear latency: clear_req sampled at edge T0 → busy=1 for cycles T0+1…T0+8.
  - Word k is cleared at edge T0+1+k.
  - busy=0 and clear_done=1 during cycle T0+9.
  - load may be accepted at the edge ending cycle T0+9.
- Back-to-back writes in consecutive cycles each get their own wr_ack pulse. wr_ack may stay high continuously.
- clear_req held high continuously: a new clear starts at the first IDLE edge after each completion. busy then drops for exactly one cycle between sequences.
- Outputs change only on clk edges or reset assertion.

## Test plan
- Reset: assert reset asynchronously mid-cycle → all qN=0, busy=0, wr_ack=0, clear_done=0 immediately, before the next edge.
- Write sweep: load=1 with address=0…7 and in=16'h1111×(N+1) on consecutive cycles.
  - Expected: q0=16'h1111 … q7=16'h8888.
  - wr_ack high for 8 consecutive cycles, each starting one cycle after its load.
- Clear with CLEAR_VALUE=16'hA5A5 after the sweep: one-cycle clear_req.
  - busy high 8 cycles; q0…q7 become 16'hA5A5 in order, one per edge.
  - clear_done pulses once in the first cycle with busy=0.
- Load during clear: load=1, address=3, in=16'hBEEF while busy=1.
  - Expected: wr_ack=0 and q3=CLEAR_VALUE after completion.
  - Repeat the same write after busy falls → q3=16'hBEEF, wr_ack=1.
- Simultaneous load and clear_req in IDLE: address=5, in=16'h1234.
  - q5=16'h1234 and wr_ack=1 in the next cycle; q5=CLEAR_VALUE after the clear completes.
- Reset mid-clear: assert reset when idx=4 → all qN=0, busy=0, no clear_done pulse. A later clear_req runs a full 8-cycle sequence.
